// File: rtl/rr_grant_encoder.sv
// Four-requester round-robin arbiter producing a binary grant index for a 2-to-4 decoder.
// Owns grant hold, release and the optional MAX_HOLD timeout; all outputs are registered.
module rr_grant_encoder #(
    parameter int MAX_HOLD = 15,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [1:0] grant_idx,
    output logic       grant_vld,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam bit               HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] HOLD_LAST = HOLD_EN ? CNT_W'(MAX_HOLD - 1) : '0;

    if (MAX_HOLD < 0 || MAX_HOLD > 255 || (2 ** CNT_W) <= MAX_HOLD) begin : g_param_check
        $error("rr_grant_encoder: MAX_HOLD must be 0..255 and fit in CNT_W bits");
    end

    state_t           state;
    logic [CNT_W-1:0] hold_cnt;
    logic [1:0]       last;
    logic [1:0]       winner;
    logic [1:0]       cand;

    // Scan from last+4 down to last+1 so the nearest requester after 'last' is written last.
    always_comb begin
        winner = last;
        cand   = last;
        for (int i = 4; i >= 1; i--) begin
            cand = last + 2'(i);
            if (req[cand]) begin
                winner = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant_idx <= 2'b00;
            grant_vld <= 1'b0;
            timeout   <= 1'b0;
            hold_cnt  <= '0;
            last      <= 2'd3;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant_idx <= winner;
                        grant_vld <= 1'b1;
                        last      <= winner;
                        hold_cnt  <= '0;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    // A normal release outranks the timeout when both happen on one edge.
                    if (done || !req[grant_idx]) begin
                        grant_vld <= 1'b0;
                        state     <= RELEASE;
                    end else if (HOLD_EN && hold_cnt == HOLD_LAST) begin
                        grant_vld <= 1'b0;
                        timeout   <= 1'b1;
                        state     <= RELEASE;
                    end else if (hold_cnt != '1) begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_grant_encoder.sv
// Directed bench for rr_grant_encoder: a per-cycle vector table plus hand-written
// sequences for the hold timeout, done-at-last-count and asynchronous reset cases.
module tb_rr_grant_encoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       done = 1'b0;
    logic [1:0] grant_idx;
    logic       grant_vld;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         rst_before;
        logic [3:0] req;
        logic       done;
        logic [1:0] idx;
        logic       vld;
        logic       to;
    } vec_t;

    vec_t vecs[$];

    rr_grant_encoder #(.MAX_HOLD(15), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [1:0] idx, input logic vld, input logic to);
        check($sformatf("%s grant_idx", tag), {6'd0, grant_idx}, {6'd0, idx});
        check($sformatf("%s grant_vld", tag), {7'd0, grant_vld}, {7'd0, vld});
        check($sformatf("%s timeout", tag),   {7'd0, timeout},   {7'd0, to});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_out("reset", 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic cycle(input logic [3:0] r, input logic d);
        @(negedge clk);
        req  = r;
        done = d;
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input bit r, input logic [3:0] rq, input logic d,
                                input logic [1:0] i, input logic v, input logic t);
        vec_t x;
        x.rst_before = r;
        x.req        = rq;
        x.done       = d;
        x.idx        = i;
        x.vld        = v;
        x.to         = t;
        vecs.push_back(x);
    endfunction

    initial begin
        logic [1:0] order2 [4];
        order2 = '{2'd1, 2'd3, 2'd1, 2'd3};

        // All four requesting: rotation 0,1,2,3,0 with three live cycles and two dead cycles each.
        for (int g = 0; g < 5; g++) begin
            logic [1:0] gi;
            gi = 2'(g);
            add(g == 0, 4'b1111, 1'b0, gi, 1'b1, 1'b0);
            add(1'b0,   4'b1111, 1'b0, gi, 1'b1, 1'b0);
            add(1'b0,   4'b1111, 1'b0, gi, 1'b1, 1'b0);
            add(1'b0,   4'b1111, 1'b1, gi, 1'b0, 1'b0);
            add(1'b0,   4'b1111, 1'b0, gi, 1'b0, 1'b0);
        end
        // Requesters 1 and 3 only: alternation wraps 3 -> 1, never 0 or 2.
        for (int g = 0; g < 4; g++) begin
            add(g == 0, 4'b1010, 1'b0, order2[g], 1'b1, 1'b0);
            add(1'b0,   4'b1010, 1'b0, order2[g], 1'b1, 1'b0);
            add(1'b0,   4'b1010, 1'b1, order2[g], 1'b0, 1'b0);
            add(1'b0,   4'b1010, 1'b0, order2[g], 1'b0, 1'b0);
        end
        // Owner 1 drops its request while 2 waits; then done with request fall; then idle glitches.
        add(1'b1, 4'b0110, 1'b0, 2'd1, 1'b1, 1'b0);
        add(1'b0, 4'b0110, 1'b0, 2'd1, 1'b1, 1'b0);
        add(1'b0, 4'b0100, 1'b0, 2'd1, 1'b0, 1'b0);
        add(1'b0, 4'b0100, 1'b0, 2'd1, 1'b0, 1'b0);
        add(1'b0, 4'b0100, 1'b0, 2'd2, 1'b1, 1'b0);
        add(1'b0, 4'b0000, 1'b1, 2'd2, 1'b0, 1'b0);
        add(1'b0, 4'b0000, 1'b0, 2'd2, 1'b0, 1'b0);
        add(1'b0, 4'b0000, 1'b1, 2'd2, 1'b0, 1'b0);
        add(1'b0, 4'b0000, 1'b0, 2'd2, 1'b0, 1'b0);

        for (int n = 0; n < vecs.size(); n++) begin
            if (vecs[n].rst_before) do_reset();
            cycle(vecs[n].req, vecs[n].done);
            check_out($sformatf("vec%0d", n), vecs[n].idx, vecs[n].vld, vecs[n].to);
        end

        // Timeout: requester 2 holds without done for exactly 15 live cycles.
        do_reset();
        cycle(4'b0100, 1'b0);
        check_out("to_grant", 2'd2, 1'b1, 1'b0);
        for (int j = 1; j <= 14; j++) begin
            cycle(4'b0100, 1'b0);
            check_out($sformatf("to_hold%0d", j), 2'd2, 1'b1, 1'b0);
        end
        cycle(4'b0100, 1'b0);
        check_out("to_revoke", 2'd2, 1'b0, 1'b1);
        cycle(4'b0100, 1'b0);
        check_out("to_pulse_end", 2'd2, 1'b0, 1'b0);
        cycle(4'b0100, 1'b0);
        check_out("to_regrant", 2'd2, 1'b1, 1'b0);

        // Done on the same edge the timeout would fire: normal release, no timeout.
        for (int j = 1; j <= 14; j++) begin
            cycle(4'b0100, 1'b0);
            check_out($sformatf("dl_hold%0d", j), 2'd2, 1'b1, 1'b0);
        end
        cycle(4'b0100, 1'b1);
        check_out("dl_release", 2'd2, 1'b0, 1'b0);
        cycle(4'b0000, 1'b0);
        check_out("dl_after", 2'd2, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a grant to requester 2.
        do_reset();
        cycle(4'b0100, 1'b0);
        check_out("ar_grant", 2'd2, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("ar_async", 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        req = 4'b1111;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_out("ar_first", 2'd0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_grant_encoder.md
Name: rr_grant_encoder

Overview:
- 4-requester round-robin arbiter that produces the 2-bit binary grant index consumed directly by the 2-to-4 line decoder.
- The decoder turns grant_idx into the one-hot grant/enable lines. This block owns all sequencing: fairness rotation, grant hold, release and timeout.
- It sits directly upstream of the decoder. grant_vld qualifies the decoder output; downstream logic ANDs each decoded line with grant_vld.

Parameters:
- MAX_HOLD, 15: maximum cycles a grant may be held in GRANT before forced revoke. 0 disables the timeout. Legal range 0..255.
- CNT_W, 8: width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request lines; req[i] is requester i. Level-sensitive; each must stay high while its grant is held.
- done  input  1  single-cycle release strobe from the current owner. Ignored outside GRANT.
- grant_idx  output  2  binary index of the current or last owner. Feeds the decoder A input.
- grant_vld  output  1  high while grant_idx is a live grant.
- timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD.

Behaviour:
- All outputs are registered. Reset is asynchronous, asserted immediately, and released synchronously with clk.
- Reset values: grant_idx=2'b00, grant_vld=0, timeout=0, state=IDLE, hold counter=0, last-owner pointer=3. Priority after reset is therefore 0,1,2,3.
- FSM has three states: IDLE, GRANT, RELEASE.
- IDLE, req==0: stay in IDLE; all outputs hold.
- IDLE, req!=0:
  - Winner is the first set bit scanning from (last+1) mod 4 upward, wrapping 3->0.
  - At that edge: grant_idx<=winner, grant_vld<=1, last<=winner, counter<=0, state->GRANT.
  - Latency: req sampled at edge k gives grant_vld high after edge k.
- GRANT: grant_idx is stable; counter increments by 1 per cycle, saturating. Exit conditions, in priority order:
  - (a) done=1, or req[grant_idx]=0: grant_vld<=0, state->RELEASE, no timeout.
  - (b) MAX_HOLD!=0 and counter==MAX_HOLD-1: grant_vld<=0, timeout<=1 for exactly one cycle, state->RELEASE.
  - (c) otherwise stay in GRANT.
- Simultaneous events:
  - done together with the timeout condition: done wins, timeout stays 0.
  - done together with req[grant_idx] falling: a single normal release.
- Requests other than the owner's are ignored while in GRANT. There is no preemption.
- RELEASE: exactly one cycle. grant_vld=0, grant_idx keeps the last owner, timeout returns to 0. Always goes to IDLE.
- Minimum gap: done sampled at edge m gives grant_vld low after m, RELEASE after m, IDLE after m+1, next grant after m+2. That is 2 dead cycles between grants.
- Fairness: a requester holding req continuously is granted within 3 other grants.
- Reset mid-GRANT: grant_vld drops asynchronously. The pointer returns to 3, and any pending requests re-arbitrate from requester 0 after reset release.
- done or req glitches outside GRANT have no effect. X on req while in IDLE is a bench error; the design does not filter it.

Test Plan:
- Reset then req=4'b1111, each grant released with done after 2 cycles -> grant_idx sequence 0,1,2,3,0, grant_vld high 3 cycles each, 2 low cycles between grants.
- req=4'b1010 steady, last=3, done after 1 cycle each -> grant_idx 1,3,1,3. Wrap from 3 to 1 is correct; 0 and 2 are never granted.
- req=4'b0100, no done, MAX_HOLD=15 -> grant_vld high exactly 15 cycles, timeout=1 on the cycle grant_vld falls, then regrant to 2 two cycles later.
- In GRANT with counter==14, assert done -> grant_vld falls, timeout stays 0.
- Owner 1 drops req[1] without done while req[2]=1 -> release next edge, then grant_idx=2 after 2 dead cycles.
- Assert rst_n=0 asynchronously mid-GRANT (owner 2) -> grant_vld=0 and grant_idx=0 before the next clk edge. After release with req=4'b1111, first grant is 0.
